id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage directly downstream of instruction fetch. Consumes if_pc/if_insn/if_en.
//  Reads the GPR file and forwards results from EX and MEM.
//  Resolves branches and returns br_taken/br_addr to fetch.
//  Detects load-use hazards and registers decoded control into the ID/EX pipeline register.
// PARAMETERS
//  WORD_W      32  data/instruction width
//  ADDR_W      30  word address width (byte addr >> 2)
//  REG_AW      5   GPR index width; link register = 5'd31
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  stall        in   1       hold ID/EX register
//  flush        in   1       load bubble into ID/EX register
//  if_pc        in   ADDR_W  PC of instruction in IF/ID
//  if_insn      in   WORD_W  instruction: [31:26] op, [25:21] ra, [20:16] rb, [15:0] imm
//  if_en        in   1       IF/ID entry valid
//  gpr_rd_addr_0/1 out REG_AW GPR read ports, driven with ra/rb (combinational)
//  gpr_rd_data_0/1 in  WORD_W GPR read data, same cycle
//  ex_en, ex_gpr_we_, ex_dst_addr, ex_fwd_data   in  1/1/REG_AW/WORD_W  EX-stage result
//  ex_mem_op_ld in   1       EX instruction is a load
//  mem_en, mem_gpr_we_, mem_dst_addr, mem_fwd_data in 1/1/REG_AW/WORD_W  MEM-stage result
//  br_taken     out  1       branch/jump taken (combinational, to fetch)
//  br_addr      out  ADDR_W  branch target word address (combinational)
//  ld_hazard    out  1       load-use hazard; controller stalls IF and PC
//  id_pc, id_en out  ADDR_W/1        registered PC / valid
//  id_alu_op    out  4       registered ALU operation
//  id_alu_in_0/1 out WORD_W  registered ALU operands
//  id_mem_op    out  2       00 NOP, 01 LDW, 10 STW
//  id_mem_wr_data out WORD_W store data
//  id_dst_addr  out  REG_AW  write-back register
//  id_gpr_we_   out  1       write-back enable, active-low
//  id_exp_code  out  2       00 none, 01 undefined opcode
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1): id_en=0, id_pc=0, id_alu_op=NOP, operands/data=0,
//   id_mem_op=NOP, id_dst_addr=0, id_gpr_we_=1, id_exp_code=0. Reset overrides stall/flush.
//  Operand select per source (ra, rb), priority order:
//   1. EX forward when ex_en & !ex_gpr_we_ & ex_dst_addr==src.
//   2. MEM forward on the same rule.
//   3. GPR read data.
//  r0 is not special.
//  ld_hazard = if_en & ex_en & ex_mem_op_ld & !ex_gpr_we_ & (ex_dst_addr==ra | ex_dst_addr==rb),
//   evaluated only when the opcode uses that source.
//  Opcodes (isa package): ADDUR 6'h04 rd=rb,ra+rb; ADDUI 6'h05 rb=ra+zext(imm);
//   LDW 6'h16 rb=mem[ra+sext(imm)]; STW 6'h17 mem[ra+sext(imm)]=rb;
//   BE 6'h0C / BNE 6'h0D compare ra,rb; CALL 6'h0E; JR 6'h0F; other = undefined.
//  Branch target:
//   - BE/BNE/CALL: br_addr = if_pc + 1 + sext(imm) mod 2^ADDR_W (wraps).
//   - JR: br_addr = ra_data[31:2].
//  br_taken = if_en & !ld_hazard & (BE&eq | BNE&!eq | CALL | JR).
//   Forced 0 while ld_hazard, undefined opcode, or if_en=0.
//  CALL writes (if_pc+1)<<2, truncated to WORD_W, to r31.
//  Address arithmetic uses a 32-bit adder; overflow is ignored.
//  ID/EX register update, priority reset > stall > flush > ld_hazard > normal:
//   - stall: all outputs hold.
//   - flush: bubble (id_en=0, id_gpr_we_=1, id_mem_op=NOP, exp=0); id_pc still latched.
//   - ld_hazard: bubble, same as flush.
//   - normal: latch decode; id_en=if_en.
//   - if_en=0 latches a bubble.
//  Undefined opcode: id_exp_code=01, id_gpr_we_=1, id_mem_op=NOP, id_en=if_en.
//  Latency: one cycle from IF/ID to ID/EX. Branch resolution is zero-cycle, combinational.
// STRUCTURE
//  Opcodes, ALU op codes, mem op codes and exp codes go in the shared isa/cpu headers.
//   No literals in this module.
//  Sub-modules:
//   - decoder: combinational decode, forwarding, hazard and branch logic.
//   - id_reg: sequential pipeline register with reset/stall/flush.
//  id_stage only wires the two together.
// TESTING
//  1. Reset held 2 cycles with stall=1, flush=1 -> id_en=0, id_gpr_we_=1, id_mem_op=00.
//  2. ADDUI r2,r1,16 with r1=5, no fwd -> next edge: id_alu_in_0=5, id_alu_in_1=16,
//     id_dst_addr=2, id_gpr_we_=0.
//  3. ADDUR r3=r1+r2 with EX writing r1=7 and MEM writing r1=9 -> alu_in_0=7 (EX wins).
//  4. EX is LDW r4; ID has ADDUR using r4 -> ld_hazard=1, br_taken=0, ID/EX bubble.
//     Hazard clears the next cycle.
//  5. BE at if_pc=30'h3FFFFFFF, imm=16'h0001, ra==rb -> br_taken=1, br_addr=30'h1 (wrap).
//     BNE in the same state -> br_taken=0.
//  6. CALL at if_pc=100 -> id_dst_addr=31, alu result operand=404, br_taken=1.
//     stall=1 with flush=1 -> outputs hold.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared ISA/CPU definitions for the decode stage: widths, opcodes,
// ALU/memory/exception codes, the ID/EX pipeline record and small helpers.
package id_stage_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;
    localparam int REG_AW = 5;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 16;

    localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADDUR = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDUI = 6'h05;
    localparam logic [OP_W-1:0] OP_BE    = 6'h0C;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h0D;
    localparam logic [OP_W-1:0] OP_CALL  = 6'h0E;
    localparam logic [OP_W-1:0] OP_JR    = 6'h0F;
    localparam logic [OP_W-1:0] OP_LDW   = 6'h16;
    localparam logic [OP_W-1:0] OP_STW   = 6'h17;

    // ALU_NOP passes alu_in_0 straight through to the result.
    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_NOP = 2'b00,
        MEM_LDW = 2'b01,
        MEM_STW = 2'b10
    } mem_op_e;

    typedef enum logic [1:0] {
        EXP_NONE  = 2'b00,
        EXP_UNDEF = 2'b01
    } exp_code_e;

    // Everything carried from ID to EX.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              en;
        alu_op_e           alu_op;
        logic [WORD_W-1:0] alu_in_0;
        logic [WORD_W-1:0] alu_in_1;
        mem_op_e           mem_op;
        logic [WORD_W-1:0] mem_wr_data;
        logic [REG_AW-1:0] dst_addr;
        logic              gpr_we_;
        exp_code_e         exp_code;
    } id_ex_t;

    localparam id_ex_t ID_EX_RESET = '{
        pc: '0, en: 1'b0, alu_op: ALU_NOP, alu_in_0: '0, alu_in_1: '0,
        mem_op: MEM_NOP, mem_wr_data: '0, dst_addr: '0, gpr_we_: 1'b1,
        exp_code: EXP_NONE
    };

    function automatic logic [WORD_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W){1'b0}}, imm};
    endfunction

    function automatic logic [WORD_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Word address following pc plus a signed word offset; wraps at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc,
                                                     input logic [IMM_W-1:0]  imm);
        logic [ADDR_W-1:0] off;
        off = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
        return pc + ADDR_W'(1) + off;
    endfunction

    // Byte address of the instruction after pc, as written to the link register.
    function automatic logic [WORD_W-1:0] link_value(input logic [ADDR_W-1:0] pc);
        logic [ADDR_W-1:0] nxt;
        nxt = pc + ADDR_W'(1);
        return {nxt, {(WORD_W-ADDR_W){1'b0}}};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle around the decode stage: IF/ID input, GPR ports, forwarding
// sources, branch feedback to fetch and the ID/EX register outputs.
interface id_stage_if;
    import id_stage_pkg::*;

    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] if_pc;
    logic [WORD_W-1:0] if_insn;
    logic              if_en;
    logic [REG_AW-1:0] gpr_rd_addr_0;
    logic [REG_AW-1:0] gpr_rd_addr_1;
    logic [WORD_W-1:0] gpr_rd_data_0;
    logic [WORD_W-1:0] gpr_rd_data_1;
    logic              ex_en;
    logic              ex_gpr_we_;
    logic [REG_AW-1:0] ex_dst_addr;
    logic [WORD_W-1:0] ex_fwd_data;
    logic              ex_mem_op_ld;
    logic              mem_en;
    logic              mem_gpr_we_;
    logic [REG_AW-1:0] mem_dst_addr;
    logic [WORD_W-1:0] mem_fwd_data;
    logic              br_taken;
    logic [ADDR_W-1:0] br_addr;
    logic              ld_hazard;
    logic [ADDR_W-1:0] id_pc;
    logic              id_en;
    alu_op_e           id_alu_op;
    logic [WORD_W-1:0] id_alu_in_0;
    logic [WORD_W-1:0] id_alu_in_1;
    mem_op_e           id_mem_op;
    logic [WORD_W-1:0] id_mem_wr_data;
    logic [REG_AW-1:0] id_dst_addr;
    logic              id_gpr_we_;
    exp_code_e         id_exp_code;

    // Pipeline environment side (fetch, register file, later stages, controller).
    modport master (
        output stall, flush, if_pc, if_insn, if_en, gpr_rd_data_0, gpr_rd_data_1,
               ex_en, ex_gpr_we_, ex_dst_addr, ex_fwd_data, ex_mem_op_ld,
               mem_en, mem_gpr_we_, mem_dst_addr, mem_fwd_data,
        input  gpr_rd_addr_0, gpr_rd_addr_1, br_taken, br_addr, ld_hazard,
               id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_mem_op,
               id_mem_wr_data, id_dst_addr, id_gpr_we_, id_exp_code
    );

    // Decode stage side.
    modport slave (
        input  stall, flush, if_pc, if_insn, if_en, gpr_rd_data_0, gpr_rd_data_1,
               ex_en, ex_gpr_we_, ex_dst_addr, ex_fwd_data, ex_mem_op_ld,
               mem_en, mem_gpr_we_, mem_dst_addr, mem_fwd_data,
        output gpr_rd_addr_0, gpr_rd_addr_1, br_taken, br_addr, ld_hazard,
               id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_mem_op,
               id_mem_wr_data, id_dst_addr, id_gpr_we_, id_exp_code
    );

endinterface

// File: rtl/id_stage_decoder.sv
// Combinational part of decode: field extraction, operand forwarding,
// load-use hazard detection, branch resolution and control generation.
module id_stage_decoder
    import id_stage_pkg::*;
(
    id_stage_if.slave bus,
    output id_ex_t    dec
);

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] ra_addr;
    logic [REG_AW-1:0] rb_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [IMM_W-1:0]  imm;

    // Register-register ops name their destination in the top bits of the immediate field.
    assign op      = bus.if_insn[WORD_W-1 -: OP_W];
    assign ra_addr = bus.if_insn[WORD_W-OP_W-1 -: REG_AW];
    assign rb_addr = bus.if_insn[WORD_W-OP_W-REG_AW-1 -: REG_AW];
    assign rd_addr = bus.if_insn[IMM_W-1 -: REG_AW];
    assign imm     = bus.if_insn[IMM_W-1:0];

    assign bus.gpr_rd_addr_0 = ra_addr;
    assign bus.gpr_rd_addr_1 = rb_addr;

    logic [REG_AW-1:0] src_addr [2];
    logic [WORD_W-1:0] gpr_data [2];
    logic [WORD_W-1:0] src_data [2];

    assign src_addr[0] = ra_addr;
    assign src_addr[1] = rb_addr;
    assign gpr_data[0] = bus.gpr_rd_data_0;
    assign gpr_data[1] = bus.gpr_rd_data_1;

    // Youngest in-flight producer wins: EX result, then MEM result, then the register file.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign src_data[gi] =
                (bus.ex_en  && !bus.ex_gpr_we_  && bus.ex_dst_addr  == src_addr[gi]) ? bus.ex_fwd_data  :
                (bus.mem_en && !bus.mem_gpr_we_ && bus.mem_dst_addr == src_addr[gi]) ? bus.mem_fwd_data :
                gpr_data[gi];
        end
    endgenerate

    logic [WORD_W-1:0] ra_data;
    logic [WORD_W-1:0] rb_data;
    logic              use_ra;
    logic              use_rb;
    logic              br_cond;
    logic [ADDR_W-1:0] br_tgt;

    assign ra_data = src_data[0];
    assign rb_data = src_data[1];

    // Per-opcode control, source usage and branch condition/target.
    always_comb begin
        dec.pc          = bus.if_pc;
        dec.en          = bus.if_en;
        dec.alu_op      = ALU_NOP;
        dec.alu_in_0    = ra_data;
        dec.alu_in_1    = rb_data;
        dec.mem_op      = MEM_NOP;
        dec.mem_wr_data = rb_data;
        dec.dst_addr    = rb_addr;
        dec.gpr_we_     = 1'b1;
        dec.exp_code    = EXP_NONE;
        use_ra          = 1'b0;
        use_rb          = 1'b0;
        br_cond         = 1'b0;
        br_tgt          = rel_target(bus.if_pc, imm);
        case (op)
            OP_ADDUR: begin
                dec.alu_op   = ALU_ADD;
                dec.dst_addr = rd_addr;
                dec.gpr_we_  = 1'b0;
                use_ra       = 1'b1;
                use_rb       = 1'b1;
            end
            OP_ADDUI: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_in_1 = zext_imm(imm);
                dec.gpr_we_  = 1'b0;
                use_ra       = 1'b1;
            end
            OP_LDW: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_in_1 = sext_imm(imm);
                dec.mem_op   = MEM_LDW;
                dec.gpr_we_  = 1'b0;
                use_ra       = 1'b1;
            end
            OP_STW: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_in_1 = sext_imm(imm);
                dec.mem_op   = MEM_STW;
                use_ra       = 1'b1;
                use_rb       = 1'b1;
            end
            OP_BE: begin
                br_cond = (ra_data == rb_data);
                use_ra  = 1'b1;
                use_rb  = 1'b1;
            end
            OP_BNE: begin
                br_cond = (ra_data != rb_data);
                use_ra  = 1'b1;
                use_rb  = 1'b1;
            end
            OP_CALL: begin
                br_cond      = 1'b1;
                dec.alu_in_0 = link_value(bus.if_pc);
                dec.alu_in_1 = '0;
                dec.dst_addr = LINK_REG;
                dec.gpr_we_  = 1'b0;
            end
            OP_JR: begin
                br_cond = 1'b1;
                br_tgt  = ra_data[WORD_W-1 -: ADDR_W];
                use_ra  = 1'b1;
            end
            default: begin
                dec.exp_code = EXP_UNDEF;
            end
        endcase
    end

    // A load still in EX cannot be forwarded yet; only sources the opcode reads matter.
    assign bus.ld_hazard = bus.if_en && bus.ex_en && bus.ex_mem_op_ld && !bus.ex_gpr_we_ &&
                           ((use_ra && bus.ex_dst_addr == ra_addr) ||
                            (use_rb && bus.ex_dst_addr == rb_addr));

    assign bus.br_taken = bus.if_en && !bus.ld_hazard && br_cond;
    assign bus.br_addr  = br_tgt;

endmodule

// File: rtl/id_stage_id_reg.sv
// ID/EX pipeline register with reset, stall (hold) and bubble insertion.
module id_stage_id_reg
    import id_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  logic   ld_hazard,
    input  id_ex_t dec,
    output id_ex_t q
);

    id_ex_t q_reg;
    id_ex_t q_next;
    logic   bubble;

    // Flush, a load-use hazard or an empty IF/ID slot all turn the slot into a no-op.
    assign bubble = flush || ld_hazard || !dec.en;

    // Hold on stall; otherwise take the decode, neutralised when bubbling (pc still follows).
    always_comb begin
        q_next = q_reg;
        if (!stall) begin
            q_next = dec;
            if (bubble) begin
                q_next.en       = 1'b0;
                q_next.gpr_we_  = 1'b1;
                q_next.mem_op   = MEM_NOP;
                q_next.exp_code = EXP_NONE;
            end
        end
    end

    // State register; reset overrides stall and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= ID_EX_RESET;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: wires the combinational decoder to the ID/EX register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    id_stage_if.slave bus
);

    id_ex_t dec;
    id_ex_t q;

    id_stage_decoder u_decoder (
        .bus (bus),
        .dec (dec)
    );

    id_stage_id_reg u_id_reg (
        .clk       (clk),
        .reset     (reset),
        .stall     (bus.stall),
        .flush     (bus.flush),
        .ld_hazard (bus.ld_hazard),
        .dec       (dec),
        .q         (q)
    );

    assign bus.id_pc          = q.pc;
    assign bus.id_en          = q.en;
    assign bus.id_alu_op      = q.alu_op;
    assign bus.id_alu_in_0    = q.alu_in_0;
    assign bus.id_alu_in_1    = q.alu_in_1;
    assign bus.id_mem_op      = q.mem_op;
    assign bus.id_mem_wr_data = q.mem_wr_data;
    assign bus.id_dst_addr    = q.dst_addr;
    assign bus.id_gpr_we_     = q.gpr_we_;
    assign bus.id_exp_code    = q.exp_code;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios followed by randomized traffic,
// checked against an instruction-level reference model.
module tb_id_stage;
    import id_stage_pkg::*;

    localparam logic [5:0] T_ADDUR = 6'h04;
    localparam logic [5:0] T_ADDUI = 6'h05;
    localparam logic [5:0] T_BE    = 6'h0C;
    localparam logic [5:0] T_BNE   = 6'h0D;
    localparam logic [5:0] T_CALL  = 6'h0E;
    localparam logic [5:0] T_JR    = 6'h0F;
    localparam logic [5:0] T_LDW   = 6'h16;
    localparam logic [5:0] T_STW   = 6'h17;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file contents seen by the stage, indexed by the instruction fields.
    logic [31:0] regs [32];
    assign bus.gpr_rd_data_0 = regs[bus.if_insn[25:21]];
    assign bus.gpr_rd_data_1 = regs[bus.if_insn[20:16]];

    int checks = 0;
    int errors = 0;

    // Expected ID/EX contents and which fields carry a defined value.
    logic [29:0] e_pc;
    logic        e_en, e_we_;
    logic [3:0]  e_alu_op;
    logic [31:0] e_in0, e_in1, e_wd;
    logic [1:0]  e_mem, e_exp;
    logic [4:0]  e_dst;
    bit          c_alu, c_in0, c_in1, c_wd, c_dst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Value an instruction sees for a source register after forwarding.
    function automatic logic [31:0] opnd(input logic [4:0] src);
        if (bus.ex_en && !bus.ex_gpr_we_ && bus.ex_dst_addr == src) return bus.ex_fwd_data;
        if (bus.mem_en && !bus.mem_gpr_we_ && bus.mem_dst_addr == src) return bus.mem_fwd_data;
        return regs[src];
    endfunction

    function automatic logic [31:0] mk_insn(input logic [5:0] op, input logic [4:0] ra,
                                            input logic [4:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    // One clock: check combinational outputs, predict the ID/EX register, check it after the edge.
    task automatic step(input string name);
        logic [5:0]  op;
        logic [4:0]  ra, rb, rd;
        logic [15:0] imm;
        logic [31:0] va, vb;
        logic [29:0] tgt;
        bit          ua, ub, haz, cond, taken, bubble;
        op  = bus.if_insn[31:26];
        ra  = bus.if_insn[25:21];
        rb  = bus.if_insn[20:16];
        rd  = bus.if_insn[15:11];
        imm = bus.if_insn[15:0];
        va  = opnd(ra);
        vb  = opnd(rb);
        ua  = op inside {T_ADDUR, T_ADDUI, T_LDW, T_STW, T_BE, T_BNE, T_JR};
        ub  = op inside {T_ADDUR, T_STW, T_BE, T_BNE};
        haz = bus.if_en && bus.ex_en && bus.ex_mem_op_ld && !bus.ex_gpr_we_ &&
              ((ua && bus.ex_dst_addr == ra) || (ub && bus.ex_dst_addr == rb));
        cond  = (op == T_BE && va == vb) || (op == T_BNE && va != vb) || op == T_CALL || op == T_JR;
        taken = bus.if_en && !haz && cond;
        if (op == T_JR) tgt = 30'(va / 4);
        else            tgt = 30'(longint'(bus.if_pc) + 1 + longint'($signed(imm)));

        #1;
        check({name, "_rd0"}, 32'(bus.gpr_rd_addr_0), 32'(ra));
        check({name, "_rd1"}, 32'(bus.gpr_rd_addr_1), 32'(rb));
        check({name, "_ld_hazard"}, 32'(bus.ld_hazard), 32'(haz));
        check({name, "_br_taken"}, 32'(bus.br_taken), 32'(taken));
        if (taken) check({name, "_br_addr"}, 32'(bus.br_addr), 32'(tgt));

        if (reset) begin
            e_pc = '0; e_en = 1'b0; e_alu_op = '0; e_in0 = '0; e_in1 = '0;
            e_mem = '0; e_wd = '0; e_dst = '0; e_we_ = 1'b1; e_exp = '0;
            {c_alu, c_in0, c_in1, c_wd, c_dst} = '1;
        end else if (!bus.stall) begin
            e_pc   = bus.if_pc;
            bubble = bus.flush || haz || !bus.if_en;
            {c_alu, c_in0, c_in1, c_wd, c_dst} = '0;
            e_en = !bubble; e_we_ = 1'b1; e_mem = 2'd0; e_exp = 2'd0;
            if (!bubble) begin
                case (op)
                    T_ADDUR: begin
                        e_alu_op = ALU_ADD; e_in0 = va; e_in1 = vb; e_dst = rd; e_we_ = 1'b0;
                        {c_alu, c_in0, c_in1, c_dst} = '1;
                    end
                    T_ADDUI: begin
                        e_alu_op = ALU_ADD; e_in0 = va; e_in1 = 32'(imm); e_dst = rb; e_we_ = 1'b0;
                        {c_alu, c_in0, c_in1, c_dst} = '1;
                    end
                    T_LDW: begin
                        e_alu_op = ALU_ADD; e_in0 = va; e_in1 = 32'($signed(imm)); e_dst = rb;
                        e_we_ = 1'b0; e_mem = 2'd1;
                        {c_alu, c_in0, c_in1, c_dst} = '1;
                    end
                    T_STW: begin
                        e_alu_op = ALU_ADD; e_in0 = va; e_in1 = 32'($signed(imm)); e_wd = vb;
                        e_mem = 2'd2;
                        {c_alu, c_in0, c_in1, c_wd} = '1;
                    end
                    T_CALL: begin
                        e_in0 = 32'((longint'(bus.if_pc) + 1) * 4); e_dst = 5'd31; e_we_ = 1'b0;
                        {c_in0, c_dst} = '1;
                    end
                    T_BE, T_BNE, T_JR: ;
                    default: e_exp = 2'd1;
                endcase
            end
        end

        @(posedge clk);
        #1;
        check({name, "_id_en"}, 32'(bus.id_en), 32'(e_en));
        check({name, "_id_pc"}, 32'(bus.id_pc), 32'(e_pc));
        check({name, "_id_gpr_we_"}, 32'(bus.id_gpr_we_), 32'(e_we_));
        check({name, "_id_mem_op"}, 32'(bus.id_mem_op), 32'(e_mem));
        check({name, "_id_exp_code"}, 32'(bus.id_exp_code), 32'(e_exp));
        if (c_alu) check({name, "_id_alu_op"}, 32'(bus.id_alu_op), 32'(e_alu_op));
        if (c_in0) check({name, "_id_alu_in_0"}, bus.id_alu_in_0, e_in0);
        if (c_in1) check({name, "_id_alu_in_1"}, bus.id_alu_in_1, e_in1);
        if (c_wd)  check({name, "_id_mem_wr_data"}, bus.id_mem_wr_data, e_wd);
        if (c_dst) check({name, "_id_dst_addr"}, 32'(bus.id_dst_addr), 32'(e_dst));
        $display("txn %s rst=%0b stall=%0b flush=%0b if_en=%0b op=%h haz=%0b taken=%0b id_en=%0b",
                 name, reset, bus.stall, bus.flush, bus.if_en, op, haz, taken, bus.id_en);
    endtask

    task automatic no_fwd();
        bus.ex_en = 1'b0; bus.ex_gpr_we_ = 1'b1; bus.ex_dst_addr = '0;
        bus.ex_fwd_data = '0; bus.ex_mem_op_ld = 1'b0;
        bus.mem_en = 1'b0; bus.mem_gpr_we_ = 1'b1; bus.mem_dst_addr = '0; bus.mem_fwd_data = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        no_fwd();
        bus.if_pc = '0; bus.if_insn = '0; bus.if_en = 1'b0;

        // 1. reset with stall and flush asserted
        reset = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        step("reset0");
        step("reset1");
        check("reset_id_en", 32'(bus.id_en), 32'd0);
        check("reset_id_gpr_we_", 32'(bus.id_gpr_we_), 32'd1);
        check("reset_id_mem_op", 32'(bus.id_mem_op), 32'd0);

        // 2. ADDUI r2,r1,16 with r1=5
        reset = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        regs[1] = 32'd5;
        bus.if_pc = 30'd10; bus.if_en = 1'b1; bus.if_insn = mk_insn(T_ADDUI, 5'd1, 5'd2, 16'd16);
        step("addui");
        check("addui_in0", bus.id_alu_in_0, 32'd5);
        check("addui_in1", bus.id_alu_in_1, 32'd16);
        check("addui_dst", 32'(bus.id_dst_addr), 32'd2);
        check("addui_we_", 32'(bus.id_gpr_we_), 32'd0);

        // 3. ADDUR r3=r1+r2, EX and MEM both write r1
        bus.ex_en = 1'b1; bus.ex_gpr_we_ = 1'b0; bus.ex_dst_addr = 5'd1; bus.ex_fwd_data = 32'd7;
        bus.mem_en = 1'b1; bus.mem_gpr_we_ = 1'b0; bus.mem_dst_addr = 5'd1; bus.mem_fwd_data = 32'd9;
        bus.if_insn = mk_insn(T_ADDUR, 5'd1, 5'd2, {5'd3, 11'd0});
        step("fwd");
        check("fwd_ex_wins", bus.id_alu_in_0, 32'd7);

        // 4. load-use hazard, then the load moves to MEM
        bus.ex_dst_addr = 5'd4; bus.ex_mem_op_ld = 1'b1; bus.ex_fwd_data = 32'hDEAD;
        bus.mem_en = 1'b0;
        bus.if_insn = mk_insn(T_ADDUR, 5'd4, 5'd2, {5'd5, 11'd0});
        step("ldhaz");
        check("ldhaz_flag", 32'(bus.ld_hazard), 32'd1);
        check("ldhaz_taken", 32'(bus.br_taken), 32'd0);
        check("ldhaz_bubble", 32'(bus.id_en), 32'd0);
        no_fwd();
        bus.mem_en = 1'b1; bus.mem_gpr_we_ = 1'b0; bus.mem_dst_addr = 5'd4; bus.mem_fwd_data = 32'd21;
        step("ldclr");
        check("ldclr_flag", 32'(bus.ld_hazard), 32'd0);
        check("ldclr_in0", bus.id_alu_in_0, 32'd21);

        // 5. BE/BNE at the top of the address space
        no_fwd();
        regs[1] = 32'd33; regs[2] = 32'd33;
        bus.if_pc = 30'h3FFFFFFF; bus.if_insn = mk_insn(T_BE, 5'd1, 5'd2, 16'h0001);
        step("be_wrap");
        check("be_taken", 32'(bus.br_taken), 32'd1);
        check("be_addr", 32'(bus.br_addr), 32'd1);
        bus.if_insn = mk_insn(T_BNE, 5'd1, 5'd2, 16'h0001);
        step("bne");
        check("bne_taken", 32'(bus.br_taken), 32'd0);

        // 6. CALL, then stall together with flush
        bus.if_pc = 30'd100; bus.if_insn = mk_insn(T_CALL, 5'd0, 5'd0, 16'd8);
        step("call");
        check("call_link", bus.id_alu_in_0, 32'd404);
        check("call_dst", 32'(bus.id_dst_addr), 32'd31);
        check("call_taken", 32'(bus.br_taken), 32'd1);
        bus.stall = 1'b1; bus.flush = 1'b1;
        bus.if_pc = 30'd200; bus.if_insn = mk_insn(T_ADDUI, 5'd1, 5'd2, 16'd16);
        step("hold");
        check("hold_link", bus.id_alu_in_0, 32'd404);
        check("hold_en", 32'(bus.id_en), 32'd1);
        check("hold_pc", 32'(bus.id_pc), 32'd100);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [5:0] rop;
            for (int i = 0; i < 4; i++) regs[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 2);
            case ($urandom_range(0, 8))
                0: rop = T_ADDUR; 1: rop = T_ADDUI; 2: rop = T_LDW; 3: rop = T_STW;
                4: rop = T_BE;    5: rop = T_BNE;   6: rop = T_CALL; 7: rop = T_JR;
                default: rop = 6'(6'h20 + $urandom_range(0, 15));
            endcase
            reset        = ($urandom_range(0, 39) == 0);
            bus.stall    = ($urandom_range(0, 7) == 0);
            bus.flush    = ($urandom_range(0, 7) == 0);
            bus.if_en    = ($urandom_range(0, 7) != 0);
            bus.if_pc    = 30'($urandom);
            bus.if_insn  = mk_insn(rop, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom));
            bus.ex_en        = 1'($urandom);
            bus.ex_gpr_we_   = 1'($urandom);
            bus.ex_mem_op_ld = 1'($urandom);
            bus.ex_dst_addr  = 5'($urandom_range(0, 3));
            bus.ex_fwd_data  = $urandom;
            bus.mem_en       = 1'($urandom);
            bus.mem_gpr_we_  = 1'($urandom);
            bus.mem_dst_addr = 5'($urandom_range(0, 3));
            bus.mem_fwd_data = $urandom;
            step($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
